// File: rtl/sram_1r1w_be_if.sv
// ---------------------------------------------------------------------------
// sram_1r1w_be_if
// Bundles the write port, read port and status signals of sram_1r1w_be.
//   master : the client. Drives wr_*, rd_en, rd_addr (and err_inj when
//            SRAM_PARITY_EN is defined). Receives rd_data, rd_valid, rd_err
//            and init_busy.
//   slave  : the memory itself, with the opposite directions.
// The SRAM_PARITY_EN macro adds the err_inj signal.
// ---------------------------------------------------------------------------
interface sram_1r1w_be_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
);
  localparam int NB = DATA_WIDTH / 8;

  logic                  init_busy;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [NB-1:0]         wr_be;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  rd_err;
`ifdef SRAM_PARITY_EN
  logic                  err_inj;
`endif

  modport master (
    output wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
`ifdef SRAM_PARITY_EN
    output err_inj,
`endif
    input  init_busy, rd_data, rd_valid, rd_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
`ifdef SRAM_PARITY_EN
    input  err_inj,
`endif
    output init_busy, rd_data, rd_valid, rd_err
  );
endinterface

// File: rtl/sram_1r1w_be.sv
// ---------------------------------------------------------------------------
// sram_1r1w_be
// 1-read / 1-write synchronous SRAM with per-byte write enables, a read
// latency of 1 or 2 cycles, a read-valid strobe and an optional
// write-to-read bypass on same-address collisions. After every reset a
// sequential engine zeroes the whole array, one word per cycle, before any
// client access is accepted.
//
// Parameters
//   DATA_WIDTH : word width, multiple of 8
//   ADDR_WIDTH : address width, DEPTH = 2**ADDR_WIDTH
//   RD_LATENCY : 1 or 2 (2 adds a register on the array output)
//   BYPASS     : 1 = collision read returns merged new data, 0 = old data
//
// Ports
//   clk  : clock, rising edge
//   rstn : asynchronous active-low reset
//   bus  : sram_1r1w_be_if slave modport (write port, read port, status)
//
// Configuration macro
//   SRAM_PARITY_EN : adds one even-parity bit per stored byte, the err_inj
//                    corruption input and a live rd_err output. Without it
//                    rd_err is constantly 0.
// ---------------------------------------------------------------------------
module sram_1r1w_be #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int RD_LATENCY = 1,
  parameter int BYPASS     = 1
) (
  input  logic          clk,
  input  logic          rstn,
  sram_1r1w_be_if.slave bus
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {
    CLEAR,
    READY
  } state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] clr_cnt_q;
  logic                  init_busy_q;

  logic                  wr_fire;
  logic                  rd_fire;
  logic                  collide;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
`ifdef SRAM_PARITY_EN
  logic [NB-1:0]         par_q [DEPTH];
  logic [NB-1:0]         rd_par;
`endif

  logic [DATA_WIDTH-1:0] rd_word_d;
  logic                  rd_perr_d;

  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_err;

  logic                  rd_valid_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_err_q;

  // Init engine: clr_cnt_q walks every address once; the word at
  // DEPTH-1 is the last one cleared, so busy drops on that same edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= CLEAR;
      clr_cnt_q   <= '0;
      init_busy_q <= 1'b1;
    end else begin
      case (state_q)
        CLEAR: begin
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (clr_cnt_q == {ADDR_WIDTH{1'b1}}) begin
            state_q     <= READY;
            init_busy_q <= 1'b0;
          end
        end
        READY: begin
          state_q <= READY;
        end
        default: begin
          state_q <= CLEAR;
        end
      endcase
    end
  end

  // Client requests are only honoured once the array has been cleared.
  assign wr_fire = bus.wr_en & (state_q == READY);
  assign rd_fire = bus.rd_en & (state_q == READY);
  assign collide = wr_fire & rd_fire & (bus.wr_addr == bus.rd_addr);

  // Storage array has no reset; the init engine owns it during CLEAR.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem_q[clr_cnt_q] <= '0;
    end else if (wr_fire) begin
      for (int b = 0; b < NB; b++) begin
        if (bus.wr_be[b]) begin
          mem_q[bus.wr_addr][8*b +: 8] <= bus.wr_data[8*b +: 8];
        end
      end
    end
  end

`ifdef SRAM_PARITY_EN
  // Even parity per byte; err_inj flips the byte-0 bit only when byte 0
  // is actually being written. Parity of an all-zero byte is 0.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      par_q[clr_cnt_q] <= '0;
    end else if (wr_fire) begin
      for (int b = 0; b < NB; b++) begin
        if (bus.wr_be[b]) begin
          par_q[bus.wr_addr][b] <= (^bus.wr_data[8*b +: 8]) ^ ((b == 0) & bus.err_inj);
        end
      end
    end
  end
`endif

  // Array read plus optional collision merge. mem_q still holds the old
  // word here, so BYPASS=0 naturally gives read-before-write. Bypassed
  // bytes get freshly computed parity, so they never report an error.
  always_comb begin
    rd_word_d = mem_q[bus.rd_addr];
`ifdef SRAM_PARITY_EN
    rd_par    = par_q[bus.rd_addr];
`endif
    if ((BYPASS != 0) && collide) begin
      for (int b = 0; b < NB; b++) begin
        if (bus.wr_be[b]) begin
          rd_word_d[8*b +: 8] = bus.wr_data[8*b +: 8];
`ifdef SRAM_PARITY_EN
          rd_par[b]           = ^bus.wr_data[8*b +: 8];
`endif
        end
      end
    end
    rd_perr_d = 1'b0;
`ifdef SRAM_PARITY_EN
    for (int b = 0; b < NB; b++) begin
      if (rd_par[b] != (^rd_word_d[8*b +: 8])) begin
        rd_perr_d = 1'b1;
      end
    end
`endif
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic                  s1_valid_q;
      logic [DATA_WIDTH-1:0] s1_data_q;
      logic                  s1_err_q;

      // Array-output register: snapshots the word at the read edge so a
      // later write cannot leak into a read already in flight.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          s1_valid_q <= 1'b0;
          s1_data_q  <= '0;
          s1_err_q   <= 1'b0;
        end else begin
          s1_valid_q <= rd_fire;
          if (rd_fire) begin
            s1_data_q <= rd_word_d;
            s1_err_q  <= rd_perr_d;
          end
        end
      end

      assign out_valid = s1_valid_q;
      assign out_data  = s1_data_q;
      assign out_err   = s1_err_q;
    end else begin : g_lat1
      assign out_valid = rd_fire;
      assign out_data  = rd_word_d;
      assign out_err   = rd_perr_d;
    end
  endgenerate

  // Output register: rd_data is only updated by a completing read so it
  // holds between reads; rd_err is qualified by the valid strobe.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_err_q   <= 1'b0;
    end else begin
      rd_valid_q <= out_valid;
      rd_err_q   <= out_valid & out_err;
      if (out_valid) begin
        rd_data_q <= out_data;
      end
    end
  end

  assign bus.init_busy = init_busy_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_err    = rd_err_q;

endmodule

// File: tb/tb_sram_1r1w_be.sv
// ---------------------------------------------------------------------------
// tb_sram_1r1w_be
// Directed bench for sram_1r1w_be. Two instances share clock, reset and
// stimulus: dutA (RD_LATENCY=1, BYPASS=1) and dutB (RD_LATENCY=2,
// BYPASS=0), so each read yields one result per configuration.
// Inputs change on the falling edge; outputs are sampled 1 ns after the
// rising edge. Define SRAM_PARITY_EN to include the parity checks.
// ---------------------------------------------------------------------------
module tb_sram_1r1w_be;

  localparam int DW = 16;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rstn;

  int passCount   = 0;
  int totalChecks = 0;

  always #5 clk = ~clk;

  sram_1r1w_be_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) busA ();
  sram_1r1w_be_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) busB ();

  // dutB sees exactly the same requests as dutA.
  assign busB.wr_en   = busA.wr_en;
  assign busB.wr_addr = busA.wr_addr;
  assign busB.wr_be   = busA.wr_be;
  assign busB.wr_data = busA.wr_data;
  assign busB.rd_en   = busA.rd_en;
  assign busB.rd_addr = busA.rd_addr;
`ifdef SRAM_PARITY_EN
  assign busB.err_inj = busA.err_inj;
`endif

  sram_1r1w_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(1), .BYPASS(1)) dutA (
    .clk  (clk),
    .rstn (rstn),
    .bus  (busA.slave)
  );

  sram_1r1w_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(2), .BYPASS(0)) dutB (
    .clk  (clk),
    .rstn (rstn),
    .bus  (busB.slave)
  );

  // Single comparison point: counts every check, reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalChecks++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One clock cycle of requests: driven at the falling edge, held across
  // the rising edge, released 1 ns later (outputs are sampled then).
  task automatic applyStimulus(input logic wrEn, input logic [AW-1:0] wrAddr, input logic [1:0] wrBe,
                               input logic [DW-1:0] wrData, input logic rdEn, input logic [AW-1:0] rdAddr);
    @(negedge clk);
    busA.wr_en   = wrEn;
    busA.wr_addr = wrAddr;
    busA.wr_be   = wrBe;
    busA.wr_data = wrData;
    busA.rd_en   = rdEn;
    busA.rd_addr = rdAddr;
    @(posedge clk);
    #1;
    busA.wr_en   = 1'b0;
    busA.wr_be   = '0;
    busA.rd_en   = 1'b0;
`ifdef SRAM_PARITY_EN
    busA.err_inj = 1'b0;
`endif
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, '0, 2'b00, '0, 1'b0, '0);
  endtask

  task automatic writeWord(input logic [AW-1:0] addr, input logic [1:0] be, input logic [DW-1:0] data);
    applyStimulus(1'b1, addr, be, data, 1'b0, '0);
  endtask

  // Issues one read, then checks dutA one cycle later and dutB two cycles
  // later, including that dutA's rd_data holds after its valid pulse.
  task automatic readCheck(input logic [AW-1:0] addr, input logic [DW-1:0] expA,
                           input logic [DW-1:0] expB, input logic expErr);
    applyStimulus(1'b0, '0, 2'b00, '0, 1'b1, addr);
    checkOutput($sformatf("rd%0d A valid", addr), busA.rd_valid, 1);
    checkOutput($sformatf("rd%0d A data", addr), busA.rd_data, expA);
    checkOutput($sformatf("rd%0d A err", addr), busA.rd_err, expErr);
    checkOutput($sformatf("rd%0d B early valid", addr), busB.rd_valid, 0);
    idleCycle();
    checkOutput($sformatf("rd%0d A valid drop", addr), busA.rd_valid, 0);
    checkOutput($sformatf("rd%0d A data hold", addr), busA.rd_data, expA);
    checkOutput($sformatf("rd%0d B valid", addr), busB.rd_valid, 1);
    checkOutput($sformatf("rd%0d B data", addr), busB.rd_data, expB);
    checkOutput($sformatf("rd%0d B err", addr), busB.rd_err, expErr);
  endtask

  initial begin
    int firstIdleA;
    int firstIdleB;
    logic validSeen;
    logic [DW-1:0] expWord;

    rstn         = 1'b0;
    busA.wr_en   = 1'b0;
    busA.wr_addr = '0;
    busA.wr_be   = '0;
    busA.wr_data = '0;
    busA.rd_en   = 1'b0;
    busA.rd_addr = '0;
`ifdef SRAM_PARITY_EN
    busA.err_inj = 1'b0;
`endif

    // Reset values while held in reset.
    #12;
    checkOutput("reset A busy", busA.init_busy, 1);
    checkOutput("reset A valid", busA.rd_valid, 0);
    checkOutput("reset A data", busA.rd_data, 0);
    checkOutput("reset A err", busA.rd_err, 0);
    checkOutput("reset B valid", busB.rd_valid, 0);
    checkOutput("reset B data", busB.rd_data, 0);

    // Init: busy for 16 cycles, reads issued during init are ignored.
    @(posedge clk);
    #1 rstn = 1'b1;
    firstIdleA = 0;
    firstIdleB = 0;
    validSeen  = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(1'b0, '0, 2'b00, '0, (k <= 16), AW'(k));
      if (!busA.init_busy && firstIdleA == 0) firstIdleA = k;
      if (!busB.init_busy && firstIdleB == 0) firstIdleB = k;
      validSeen = validSeen | busA.rd_valid | busB.rd_valid;
    end
    checkOutput("init A cycles", firstIdleA, 16);
    checkOutput("init B cycles", firstIdleB, 16);
    checkOutput("init reads ignored", validSeen, 0);
    for (int a = 0; a < 16; a++) begin
      readCheck(AW'(a), 16'h0000, 16'h0000, 1'b0);
    end

    // Byte enables.
    writeWord(4'd3, 2'b11, 16'hABCD);
    writeWord(4'd3, 2'b01, 16'h1234);
    readCheck(4'd3, 16'hAB34, 16'hAB34, 1'b0);
    writeWord(4'd3, 2'b00, 16'hFFFF);
    readCheck(4'd3, 16'hAB34, 16'hAB34, 1'b0);

    // Same-address collision: A bypasses (merged), B reads old data.
    writeWord(4'd5, 2'b11, 16'h1111);
    applyStimulus(1'b1, 4'd5, 2'b10, 16'h2222, 1'b1, 4'd5);
    checkOutput("coll A valid", busA.rd_valid, 1);
    checkOutput("coll A data", busA.rd_data, 16'h2211);
    checkOutput("coll A err", busA.rd_err, 0);
    idleCycle();
    checkOutput("coll B valid", busB.rd_valid, 1);
    checkOutput("coll B data", busB.rd_data, 16'h1111);
    readCheck(4'd5, 16'h2211, 16'h2211, 1'b0);

    // Fill, then 16 back-to-back reads: continuous valid, in order.
    for (int i = 0; i < 16; i++) begin
      writeWord(AW'(i), 2'b11, 16'(i) * 16'h0101);
    end
    for (int k = 0; k < 18; k++) begin
      applyStimulus(1'b0, '0, 2'b00, '0, (k < 16), AW'(k));
      checkOutput($sformatf("stream%0d A valid", k), busA.rd_valid, (k < 16));
      if (k < 16) begin
        expWord = 16'(k) * 16'h0101;
        checkOutput($sformatf("stream%0d A data", k), busA.rd_data, expWord);
      end
      checkOutput($sformatf("stream%0d B valid", k), busB.rd_valid, (k >= 1 && k <= 16));
      if (k >= 1 && k <= 16) begin
        expWord = 16'(k - 1) * 16'h0101;
        checkOutput($sformatf("stream%0d B data", k), busB.rd_data, expWord);
      end
    end

    // Write one cycle after a latency-2 read must not change its data.
    applyStimulus(1'b0, '0, 2'b00, '0, 1'b1, 4'd6);
    checkOutput("war A data", busA.rd_data, 16'h0606);
    writeWord(4'd6, 2'b11, 16'hBEEF);
    checkOutput("war B valid", busB.rd_valid, 1);
    checkOutput("war B data", busB.rd_data, 16'h0606);
    readCheck(4'd6, 16'hBEEF, 16'hBEEF, 1'b0);

    // Reset during an in-flight read aborts it and reruns the clear.
    applyStimulus(1'b0, '0, 2'b00, '0, 1'b1, 4'd2);
    checkOutput("mid A data", busA.rd_data, 16'h0202);
    rstn = 1'b0;
    #1;
    checkOutput("mid rst A valid", busA.rd_valid, 0);
    checkOutput("mid rst A data", busA.rd_data, 0);
    checkOutput("mid rst A busy", busA.init_busy, 1);
    checkOutput("mid rst B valid", busB.rd_valid, 0);
    checkOutput("mid rst B data", busB.rd_data, 0);
    @(posedge clk);
    #1;
    checkOutput("mid rst B flushed", busB.rd_valid, 0);
    rstn = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      applyStimulus((k == 1), 4'd9, 2'b11, 16'h9999, 1'b0, '0);
      if (k == 15) checkOutput("reinit busy 15", busA.init_busy, 1);
      if (k == 16) checkOutput("reinit busy 16", busA.init_busy, 0);
    end
    readCheck(4'd2, 16'h0000, 16'h0000, 1'b0);
    readCheck(4'd9, 16'h0000, 16'h0000, 1'b0);
    readCheck(4'd3, 16'h0000, 16'h0000, 1'b0);

`ifdef SRAM_PARITY_EN
    // Parity error injection on byte 0.
    busA.err_inj = 1'b1;
    writeWord(4'd7, 2'b11, 16'h00FF);
    readCheck(4'd7, 16'h00FF, 16'h00FF, 1'b1);
    readCheck(4'd6, 16'h0000, 16'h0000, 1'b0);
    writeWord(4'd7, 2'b11, 16'h00FF);
    readCheck(4'd7, 16'h00FF, 16'h00FF, 1'b0);
    // Injection ignored when byte 0 is not written.
    busA.err_inj = 1'b1;
    writeWord(4'd8, 2'b10, 16'h5500);
    readCheck(4'd8, 16'h5500, 16'h5500, 1'b0);
    // Bypassed collision data carries good parity; the stored word does not.
    busA.err_inj = 1'b1;
    applyStimulus(1'b1, 4'd7, 2'b11, 16'h0F0F, 1'b1, 4'd7);
    checkOutput("pcoll A data", busA.rd_data, 16'h0F0F);
    checkOutput("pcoll A err", busA.rd_err, 0);
    idleCycle();
    checkOutput("pcoll B data", busB.rd_data, 16'h00FF);
    checkOutput("pcoll B err", busB.rd_err, 0);
    readCheck(4'd7, 16'h0F0F, 16'h0F0F, 1'b1);
`endif

    $display("[TB] %0d/%0d checks passed", passCount, totalChecks);
    $finish;
  end

endmodule
